// File: rtl/decoder_scan_ctrl.sv
// Select-code sequencer for a one-hot decoder: steps A_out through up, down,
// ping-pong or single-sweep patterns, holding each index for div+1 cycles.
module decoder_scan_ctrl #(
  parameter int WIDTH_OUT = 3,
  parameter int DIV_W     = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic                 stop_in,
  input  logic [1:0]           mode_in,
  input  logic [DIV_W-1:0]     div_in,
  output logic [WIDTH_OUT-1:0] A_out,
  output logic                 valid_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 wrap_out
);

  localparam logic [WIDTH_OUT-1:0] ZERO_IDX = {WIDTH_OUT{1'b0}};
  localparam logic [WIDTH_OUT-1:0] ONE_IDX  = {{(WIDTH_OUT-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_OUT-1:0] MAX_IDX  = {WIDTH_OUT{1'b1}};
  localparam logic [DIV_W-1:0]     ZERO_DIV = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]     ONE_DIV  = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic [1:0] {
    MODE_UP    = 2'b00,
    MODE_DOWN  = 2'b01,
    MODE_PING  = 2'b10,
    MODE_SWEEP = 2'b11
  } mode_t;

  state_t               state_r;
  mode_t                mode_r;
  logic [DIV_W-1:0]     div_r;
  logic [DIV_W-1:0]     presc_r;
  logic                 dir_up_r;

  logic                 start_go_s;
  logic [WIDTH_OUT-1:0] init_idx_s;
  logic [WIDTH_OUT-1:0] step_idx_s;
  logic                 step_dir_up_s;
  logic                 step_wrap_s;
  logic                 step_done_s;

  assign start_go_s = start_in & ~stop_in;
  assign init_idx_s = (mode_in == MODE_DOWN) ? MAX_IDX : ZERO_IDX;

  // Next index, direction and event flags for the step due when the dwell expires
  always_comb begin
    step_idx_s    = A_out;
    step_dir_up_s = dir_up_r;
    step_wrap_s   = 1'b0;
    step_done_s   = 1'b0;
    case (mode_r)
      MODE_UP: begin
        step_idx_s  = A_out + ONE_IDX;
        step_wrap_s = (A_out == MAX_IDX);
      end
      MODE_DOWN: begin
        step_idx_s  = A_out - ONE_IDX;
        step_wrap_s = (A_out == ZERO_IDX);
      end
      MODE_PING: begin
        // Endpoints are shown once; the reversal step is the wrap event
        if (dir_up_r) begin
          if (A_out == MAX_IDX) begin
            step_idx_s    = MAX_IDX - ONE_IDX;
            step_dir_up_s = 1'b0;
            step_wrap_s   = 1'b1;
          end else begin
            step_idx_s = A_out + ONE_IDX;
          end
        end else begin
          if (A_out == ZERO_IDX) begin
            step_idx_s    = ONE_IDX;
            step_dir_up_s = 1'b1;
            step_wrap_s   = 1'b1;
          end else begin
            step_idx_s = A_out - ONE_IDX;
          end
        end
      end
      MODE_SWEEP: begin
        if (A_out == MAX_IDX) begin
          step_done_s = 1'b1;
        end else begin
          step_idx_s = A_out + ONE_IDX;
        end
      end
      default: begin
        step_idx_s = A_out;
      end
    endcase
  end

  // Scan state machine with registered select code and status outputs
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r   <= IDLE;
      mode_r    <= MODE_UP;
      div_r     <= ZERO_DIV;
      presc_r   <= ZERO_DIV;
      dir_up_r  <= 1'b1;
      A_out     <= ZERO_IDX;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      wrap_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      wrap_out <= 1'b0;
      if (start_go_s) begin
        // Start from IDLE and restart from RUN share one load path
        state_r   <= RUN;
        mode_r    <= mode_t'(mode_in);
        div_r     <= div_in;
        presc_r   <= ZERO_DIV;
        dir_up_r  <= (mode_in != MODE_DOWN);
        A_out     <= init_idx_s;
        valid_out <= 1'b1;
        busy_out  <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            presc_r <= ZERO_DIV;
          end
          RUN: begin
            if (stop_in) begin
              state_r   <= IDLE;
              valid_out <= 1'b0;
              busy_out  <= 1'b0;
            end else if (presc_r == div_r) begin
              presc_r  <= ZERO_DIV;
              A_out    <= step_idx_s;
              dir_up_r <= step_dir_up_s;
              wrap_out <= step_wrap_s;
              if (step_done_s) begin
                state_r   <= IDLE;
                valid_out <= 1'b0;
                busy_out  <= 1'b0;
                done_out  <= 1'b1;
              end
            end else begin
              presc_r <= presc_r + ONE_DIV;
            end
          end
          default: begin
            state_r   <= IDLE;
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: each driven cycle queues the expected
// {A, valid, busy, done, wrap}, popped and compared one edge later.
module tb_decoder_scan_ctrl;

  logic       clk_in;
  logic       rst_n_in;
  logic       start_in;
  logic       stop_in;
  logic [1:0] mode_in;
  logic [7:0] div_in;
  logic [2:0] A_out;
  logic       valid_out;
  logic       busy_out;
  logic       done_out;
  logic       wrap_out;

  typedef struct packed {
    logic [2:0] a;
    logic       valid;
    logic       busy;
    logic       done;
    logic       wrap;
  } exp_t;

  exp_t sb_q[$];
  int   checks_cnt;
  int   errors_cnt;

  decoder_scan_ctrl #(.WIDTH_OUT(3), .DIV_W(8)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .start_in  (start_in),
    .stop_in   (stop_in),
    .mode_in   (mode_in),
    .div_in    (div_in),
    .A_out     (A_out),
    .valid_out (valid_out),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .wrap_out  (wrap_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h (A,valid,busy,done,wrap)", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int a, input logic v, input logic d, input logic w);
    exp_t e;
    e.a     = 3'(a);
    e.valid = v;
    e.busy  = v;
    e.done  = d;
    e.wrap  = w;
    return e;
  endfunction

  // Drive one cycle, queue its expectation, then compare after the edge
  task automatic cyc(input logic st, input logic sp, input logic [1:0] md,
                     input logic [7:0] dv, input exp_t e, input string tag);
    exp_t exp_v;
    start_in = st;
    stop_in  = sp;
    mode_in  = md;
    div_in   = dv;
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    exp_v = sb_q.pop_front();
    check_val(tag, {9'd0, A_out, valid_out, busy_out, done_out, wrap_out}, {9'd0, exp_v});
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n_in   = 1'b0;
    start_in   = 1'b0;
    stop_in    = 1'b0;
    mode_in    = 2'b00;
    div_in     = 8'd0;

    // Reset, then idle
    cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(0, 1'b0, 1'b0, 1'b0), "reset0");
    cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(0, 1'b0, 1'b0, 1'b0), "reset1");
    rst_n_in = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(0, 1'b0, 1'b0, 1'b0), "idle");

    // Up-continuous div=0; live mode/div changes must be ignored
    cyc(1'b1, 1'b0, 2'b00, 8'd0, mk(0, 1'b1, 1'b0, 1'b0), "up_start");
    for (int t = 1; t <= 9; t++)
      cyc(1'b0, 1'b0, 2'b01, 8'd5, mk(t % 8, 1'b1, 1'b0, (t % 8) == 0), "up_seq");
    cyc(1'b0, 1'b1, 2'b00, 8'd0, mk(1, 1'b0, 1'b0, 1'b0), "up_stop");

    // Down-continuous div=2
    cyc(1'b1, 1'b0, 2'b01, 8'd2, mk(7, 1'b1, 1'b0, 1'b0), "down_start");
    for (int t = 1; t <= 26; t++)
      cyc(1'b0, 1'b0, 2'b01, 8'd2,
          mk(7 - t / 3, 1'b1, 1'b0, (t % 3 == 0) && (3'(7 - t / 3) == 3'd7)), "down_seq");
    cyc(1'b0, 1'b1, 2'b01, 8'd2, mk(7, 1'b0, 1'b0, 1'b0), "down_stop");

    // Ping-pong div=0
    cyc(1'b1, 1'b0, 2'b10, 8'd0, mk(0, 1'b1, 1'b0, 1'b0), "ping_start");
    for (int p = 1; p <= 16; p++) begin
      int pos;
      pos = p % 14;
      cyc(1'b0, 1'b0, 2'b10, 8'd0,
          mk((pos <= 7) ? pos : 14 - pos, 1'b1, 1'b0, (pos == 8) || (pos == 1 && p > 1)),
          "ping_seq");
    end
    cyc(1'b0, 1'b1, 2'b10, 8'd0, mk(2, 1'b0, 1'b0, 1'b0), "ping_stop");

    // Single sweep div=1
    cyc(1'b1, 1'b0, 2'b11, 8'd1, mk(0, 1'b1, 1'b0, 1'b0), "sweep_start");
    for (int t = 1; t <= 15; t++)
      cyc(1'b0, 1'b0, 2'b11, 8'd1, mk(t / 2, 1'b1, 1'b0, 1'b0), "sweep_seq");
    cyc(1'b0, 1'b0, 2'b11, 8'd1, mk(7, 1'b0, 1'b1, 1'b0), "sweep_done");
    for (int t = 0; t < 3; t++)
      cyc(1'b0, 1'b0, 2'b11, 8'd1, mk(7, 1'b0, 1'b0, 1'b0), "sweep_after");

    // Stop at A=4
    cyc(1'b1, 1'b0, 2'b00, 8'd0, mk(0, 1'b1, 1'b0, 1'b0), "stop4_start");
    for (int t = 1; t <= 4; t++)
      cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(t, 1'b1, 1'b0, 1'b0), "stop4_seq");
    cyc(1'b0, 1'b1, 2'b00, 8'd0, mk(4, 1'b0, 1'b0, 1'b0), "stop4_stop");
    cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(4, 1'b0, 1'b0, 1'b0), "stop4_hold");

    // start and stop together: stop wins in RUN, nothing happens in IDLE
    cyc(1'b1, 1'b0, 2'b00, 8'd0, mk(0, 1'b1, 1'b0, 1'b0), "both_start");
    cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(1, 1'b1, 1'b0, 1'b0), "both_seq");
    cyc(1'b1, 1'b1, 2'b00, 8'd0, mk(1, 1'b0, 1'b0, 1'b0), "both_run");
    cyc(1'b1, 1'b1, 2'b01, 8'd0, mk(1, 1'b0, 1'b0, 1'b0), "both_idle");

    // Restart at A=5 in mode 00
    cyc(1'b1, 1'b0, 2'b00, 8'd0, mk(0, 1'b1, 1'b0, 1'b0), "rst5_start");
    for (int t = 1; t <= 5; t++)
      cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(t, 1'b1, 1'b0, 1'b0), "rst5_seq");
    cyc(1'b1, 1'b0, 2'b00, 8'd0, mk(0, 1'b1, 1'b0, 1'b0), "rst5_restart");
    cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(1, 1'b1, 1'b0, 1'b0), "rst5_next");

    // Reset mid-scan
    cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(2, 1'b1, 1'b0, 1'b0), "rstmid_pre");
    rst_n_in = 1'b0;
    cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(0, 1'b0, 1'b0, 1'b0), "rstmid");
    rst_n_in = 1'b1;
    cyc(1'b0, 1'b0, 2'b00, 8'd0, mk(0, 1'b0, 1'b0, 1'b0), "rstmid_idle");

    // Maximum dwell: div=255 holds each index 256 cycles
    cyc(1'b1, 1'b0, 2'b00, 8'd255, mk(0, 1'b1, 1'b0, 1'b0), "maxdiv_start");
    for (int t = 1; t <= 257; t++)
      cyc(1'b0, 1'b0, 2'b00, 8'd255, mk(t / 256, 1'b1, 1'b0, 1'b0), "maxdiv_seq");
    cyc(1'b0, 1'b1, 2'b00, 8'd255, mk(1, 1'b0, 1'b0, 1'b0), "maxdiv_stop");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
